bit_rev_scheduler: RTL and testbench

BIT_REV_SCHEDULER -- requirements
Module: bit_rev_scheduler

---
 rtl/bit_rev_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 36 +++
 rtl/bit_rev_scheduler.sv | 123 ++++++++++++
 tb/tb_bit_rev_scheduler.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bit_rev_pkg.sv
// rtl/bit_rev_pkg.sv - shared state encoding for the bit-reversal scheduler
// Purpose: FSM state typedef and its encoding constants.
// Ports:   none (package).
package bit_rev_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      SHIFT = ST_SHIFT,
      DONE  = ST_DONE
   } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant selection
// Purpose: pick one requester, searching from last_grant+1 upward modulo NUM_REQ.
// Ports:   req        - request vector
//          last_grant - index of the most recently accepted requester
//          grant      - one-hot grant
//          grant_idx  - index of the granted requester
//          any        - high when some requester is granted
module rr_arbiter #(
   parameter  int NUM_REQ = 4,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    last_grant,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_idx,
   output logic               any
);

   always_comb begin
      int idx;
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      idx       = 0;
      // Offset NUM_REQ wraps back to last_grant itself, so it is searched last.
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(last_grant) + k) % NUM_REQ;
         if (!any && req[idx]) begin
            grant[idx] = 1'b1;
            grant_idx  = ID_W'(idx);
            any        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bit_rev_scheduler.sv
// rtl/bit_rev_scheduler.sv - round-robin word scheduler with serial bit reversal
// Purpose: accept one word from NUM_REQ requesters, bit-reverse it over
//          DATA_WIDTH shift cycles and present it with its requester index.
// Ports:   clk, resetn          - clock, asynchronous active-low reset
//          req_valid/req_data   - per-requester offer and word
//          req_ready            - one-hot acceptance strobe
//          out_valid/out_ready  - result handshake
//          out_data/out_id      - reversed word and owning requester
//          busy                 - high whenever the FSM is not idle
module bit_rev_scheduler
   import bit_rev_pkg::*;
#(
   parameter  int DATA_WIDTH = 32,
   parameter  int NUM_REQ    = 4,
   localparam int ID_W       = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          out_valid,
   output logic [DATA_WIDTH-1:0]         out_data,
   output logic [ID_W-1:0]               out_id,
   input  logic                          out_ready,
   output logic                          busy
);

   localparam int CNT_W = $clog2(DATA_WIDTH + 1);

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] src_q, src_d;
   logic [DATA_WIDTH-1:0] res_q, res_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic [ID_W-1:0]       id_q, id_d;
   logic [ID_W-1:0]       out_id_q, out_id_d;
   logic [ID_W-1:0]       last_grant_q, last_grant_d;

   logic [NUM_REQ-1:0]    grant;
   logic [ID_W-1:0]       grant_idx;
   logic                  grant_any;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req        (req_valid),
      .last_grant (last_grant_q),
      .grant      (grant),
      .grant_idx  (grant_idx),
      .any        (grant_any)
   );

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      src_d        = src_q;
      res_d        = res_q;
      out_data_d   = out_data_q;
      id_d         = id_q;
      out_id_d     = out_id_q;
      last_grant_d = last_grant_q;
      req_ready    = '0;

      case (state_q)
         IDLE: begin
            // resetn gating keeps req_ready quiet while reset is held low.
            if (grant_any && resetn) begin
               req_ready    = grant;
               src_d        = req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
               id_d         = grant_idx;
               last_grant_d = grant_idx;
               res_d        = '0;
               cnt_d        = '0;
               state_d      = SHIFT;
            end
         end
         SHIFT: begin
            res_d = {res_q[DATA_WIDTH-2:0], src_q[0]};
            src_d = src_q >> 1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
               // Output registers load only here so they hold outside DONE.
               out_data_d = res_d;
               out_id_d   = id_q;
               state_d    = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         src_q        <= '0;
         res_q        <= '0;
         out_data_q   <= '0;
         id_q         <= '0;
         out_id_q     <= '0;
         last_grant_q <= ID_W'(NUM_REQ - 1);
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         src_q        <= src_d;
         res_q        <= res_d;
         out_data_q   <= out_data_d;
         id_q         <= id_d;
         out_id_q     <= out_id_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign out_data  = out_data_q;
   assign out_id    = out_id_q;

endmodule

// File: tb/tb_bit_rev_scheduler.sv
// tb/tb_bit_rev_scheduler.sv - scoreboard bench for bit_rev_scheduler
module tb_bit_rev_scheduler;

   logic         clk = 1'b0;
   logic         resetn;
   logic         out_ready;

   logic [3:0]   req_valid;
   logic [31:0]  req_data;
   logic [3:0]   req_ready;
   logic         out_valid;
   logic [7:0]   out_data;
   logic [1:0]   out_id;
   logic         busy;

   logic [3:0]   req_valid32;
   logic [127:0] req_data32;
   logic [3:0]   req_ready32;
   logic         out_valid32;
   logic [31:0]  out_data32;
   logic [1:0]   out_id32;
   logic         busy32;

   int total = 0;
   int bad   = 0;

   logic [9:0]  sb8[$];
   logic [33:0] sb32[$];
   int          grant_log[$];
   bit          log_en = 1'b0;
   logic [3:0]  prev_rr = '0;

   always #5 clk = ~clk;

   bit_rev_scheduler #(.DATA_WIDTH(8), .NUM_REQ(4)) dut8 (
      .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data),
      .out_id(out_id), .out_ready(out_ready), .busy(busy)
   );

   bit_rev_scheduler #(.DATA_WIDTH(32), .NUM_REQ(4)) dut32 (
      .clk(clk), .resetn(resetn), .req_valid(req_valid32), .req_data(req_data32),
      .req_ready(req_ready32), .out_valid(out_valid32), .out_data(out_data32),
      .out_id(out_id32), .out_ready(out_ready), .busy(busy32)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitors: pop and compare on every output handshake.
   always @(negedge clk) begin
      if (resetn && out_valid && out_ready) begin
         if (sb8.size() == 0) begin
            chk("unexpected_out8", {54'd0, out_id, out_data}, 64'hDEAD);
         end else begin
            logic [9:0] e;
            e = sb8.pop_front();
            chk("out8_data", 64'(out_data), 64'(e[7:0]));
            chk("out8_id", 64'(out_id), 64'(e[9:8]));
         end
      end
   end

   always @(negedge clk) begin
      if (resetn && out_valid32 && out_ready) begin
         if (sb32.size() == 0) begin
            chk("unexpected_out32", {30'd0, out_id32, out_data32}, 64'hDEAD);
         end else begin
            logic [33:0] e;
            e = sb32.pop_front();
            chk("out32_data", 64'(out_data32), 64'(e[31:0]));
            chk("out32_id", 64'(out_id32), 64'(e[33:32]));
         end
      end
   end

   always @(negedge clk) begin
      if (log_en && req_ready != 4'b0000) begin
         chk("rr_onehot", 64'($onehot(req_ready)), 64'd1);
         chk("rr_pulse_width", 64'(prev_rr), 64'd0);
         for (int i = 0; i < 4; i++) if (req_ready[i]) grant_log.push_back(i);
      end
      prev_rr <= req_ready;
   end

   task automatic do_reset();
      resetn = 1'b0;
      #2;
      chk("rst_ready", 64'(req_ready), 64'd0);
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_data", 64'(out_data), 64'd0);
      chk("rst_id", 64'(out_id), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      @(posedge clk); #1;
      resetn = 1'b1;
   endtask

   task automatic wait_sb_empty(input string name);
      int c;
      c = 0;
      while (sb8.size() != 0 && c < 60) begin @(negedge clk); #1; c++; end
      chk(name, 64'(sb8.size()), 64'd0);
   endtask

   // Single-requester transaction starting at posedge+1 (cycle 0), DUT idle.
   task automatic send8(input int id, input logic [7:0] din, input logic [7:0] exp,
                        input bit scramble);
      int  lat;
      bit  got;
      req_valid = '0;
      req_valid[id] = 1'b1;
      req_data[id*8 +: 8] = din;
      @(negedge clk);
      chk("send_ready", 64'(req_ready), 64'(4'b0001 << id));
      sb8.push_back({2'(id), exp});
      @(posedge clk); #1;
      req_valid = '0;
      lat = 0;
      got = 1'b0;
      for (int c = 1; c <= 40 && !got; c++) begin
         @(negedge clk);
         if (c == 1) chk("send_busy", 64'(busy), 64'd1);
         if (scramble && c == 4) req_data[id*8 +: 8] = ~din;
         if (out_valid) begin got = 1'b1; lat = c; end
      end
      chk("send_latency", 64'(lat), 64'd9);
      @(posedge clk); #1;
   endtask

   initial begin
      int c;
      resetn      = 1'b1;
      out_ready   = 1'b1;
      req_valid   = '0;
      req_data    = '0;
      req_valid32 = '0;
      req_data32  = '0;
      @(posedge clk); #1;
      do_reset();

      // Requester 2 alone, 0x01 -> 0x80.
      send8(2, 8'h01, 8'h80, 1'b0);
      chk("out_hold_idle", 64'(out_data), 64'h80);

      // All requesters continuously valid: grant order 0,1,2,3,0.
      do_reset();
      req_data  = {8'h10, 8'h03, 8'h02, 8'h01};
      sb8.push_back({2'd0, 8'h80});
      sb8.push_back({2'd1, 8'h40});
      sb8.push_back({2'd2, 8'hC0});
      sb8.push_back({2'd3, 8'h08});
      sb8.push_back({2'd0, 8'h80});
      log_en    = 1'b1;
      req_valid = 4'b1111;
      c = 0;
      while (grant_log.size() < 5 && c < 100) begin @(negedge clk); #1; c++; end
      chk("rr_grant_count", 64'(grant_log.size()), 64'd5);
      @(posedge clk); #1;
      req_valid = '0;
      log_en    = 1'b0;
      wait_sb_empty("rr_drain");
      begin
         int exp_order[5];
         exp_order = '{0, 1, 2, 3, 0};
         for (int i = 0; i < 5 && i < grant_log.size(); i++)
            chk("rr_order", 64'(grant_log[i]), 64'(exp_order[i]));
      end

      // Back-pressure: requester 1, 0x1E -> 0x78, held for 5 cycles.
      do_reset();
      out_ready = 1'b0;
      req_valid = 4'b0010;
      req_data[15:8] = 8'h1E;
      @(negedge clk);
      chk("bp_ready", 64'(req_ready), 64'b0010);
      sb8.push_back({2'd1, 8'h78});
      @(posedge clk); #1;
      req_valid = 4'b0001;
      c = 0;
      while (!out_valid && c < 40) begin @(negedge clk); c++; end
      chk("bp_valid_seen", 64'(out_valid), 64'd1);
      for (int i = 0; i < 5; i++) begin
         chk("bp_data", 64'(out_data), 64'h78);
         chk("bp_id", 64'(out_id), 64'd1);
         chk("bp_busy", 64'(busy), 64'd1);
         chk("bp_rdy", 64'(req_ready), 64'd0);
         chk("bp_valid", 64'(out_valid), 64'd1);
         @(negedge clk);
      end
      @(posedge clk); #1;
      req_valid = '0;
      out_ready = 1'b1;
      wait_sb_empty("bp_drain");
      @(negedge clk);
      chk("bp_valid_after", 64'(out_valid), 64'd0);
      chk("bp_data_retained", 64'(out_data), 64'h78);
      @(posedge clk); #1;

      // Reset in the 4th SHIFT cycle discards the word; requester 0 wins after.
      req_valid = 4'b0001;
      req_data[7:0] = 8'h55;
      @(negedge clk);
      chk("rst_mid_accept", 64'(req_ready), 64'b0001);
      for (int i = 0; i < 4; i++) begin @(posedge clk); #1; req_valid = '0; end
      req_valid = 4'b1001;
      req_data  = {8'h0C, 8'h00, 8'h00, 8'hF0};
      resetn    = 1'b0;
      #2;
      chk("rst_mid_rdy", 64'(req_ready), 64'd0);
      chk("rst_mid_busy", 64'(busy), 64'd0);
      chk("rst_mid_valid", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
      resetn    = 1'b1;
      @(negedge clk);
      chk("rst_prio", 64'(req_ready), 64'b0001);
      sb8.push_back({2'd0, 8'h0F});
      sb8.push_back({2'd3, 8'h30});
      @(posedge clk); #1;
      req_valid = 4'b1000;
      c = 0;
      while (req_ready != 4'b1000 && c < 40) begin @(negedge clk); c++; end
      chk("rst_second_grant", 64'(req_ready), 64'b1000);
      @(posedge clk); #1;
      req_valid = '0;
      wait_sb_empty("rst_drain");
      @(posedge clk); #1;

      // Edge values and mid-shift data change.
      send8(3, 8'h00, 8'h00, 1'b0);
      send8(3, 8'hFF, 8'hFF, 1'b0);
      send8(0, 8'hA5, 8'hA5, 1'b0);
      send8(1, 8'h0F, 8'hF0, 1'b1);
      wait_sb_empty("edge_drain");

      // 32-bit instance: 0x1 -> 0x80000000, first valid in cycle 33.
      req_valid32 = 4'b0001;
      req_data32[31:0] = 32'h0000_0001;
      @(negedge clk);
      chk("w32_ready", 64'(req_ready32), 64'b0001);
      sb32.push_back({2'd0, 32'h8000_0000});
      @(posedge clk); #1;
      req_valid32 = '0;
      begin
         int lat;
         lat = 0;
         for (int k = 1; k <= 60 && lat == 0; k++) begin
            @(negedge clk);
            if (out_valid32) lat = k;
         end
         chk("w32_latency", 64'(lat), 64'd33);
      end
      @(posedge clk); #1;
      chk("w32_drain", 64'(sb32.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
